// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard request bundle and the forward/stall/flush controls returned to the pipeline.
// The pipeline drives the master side; the hazard unit sits on the slave side.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1use;
  logic              rs2use;
  logic [REG_AW-1:0] rd_addr;
  logic [1:0]        hazard_optype;
  logic [1:0]        md_op;
  logic              branch_taken;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall_pc;
  logic              stall_ifid;
  logic              flush_ifid;
  logic              flush_idex;
  logic              md_busy;

  modport master (
    output id_valid, rs1_addr, rs2_addr, rs1use, rs2use, rd_addr,
           hazard_optype, md_op, branch_taken,
    input  fwd_a, fwd_b, stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy
  );

  modport slave (
    input  id_valid, rs1_addr, rs2_addr, rs1use, rs2use, rd_addr,
           hazard_optype, md_op, branch_taken,
    output fwd_a, fwd_b, stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: shadows EX/MEM/WB producer records, selects operand forwarding,
// raises load-use / no-forward / mul-div stalls and gates taken-branch flushes.
module hazard_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter bit FWD_EN  = 1'b1
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz_if
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  typedef struct packed {
    logic [1:0]        optype;
    logic [REG_AW-1:0] rd;
    logic              is_md;
  } rec_t;

  localparam rec_t BUBBLE = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  rec_t      ex_q, ex_d;
  rec_t      mem_q, mem_d;
  rec_t      wb_q, wb_d;
  rec_t      id_rec;
  md_state_e st_q, st_d;
  logic [3:0] cnt_q, cnt_d;

  logic       live_a, live_b;
  logic [1:0] sel_a, sel_b;
  logic       lu_a, lu_b;
  logic       any_a, any_b;
  logic       raw_stall;
  logic       busy;
  logic       stall;
  logic       md_in_id;
  logic       md_go;
  logic [3:0] md_cnt;
  logic       unused_wb_md;

  function automatic logic is_producer(input rec_t r);
    return (r.optype == OP_ALU) || (r.optype == OP_LOAD);
  endfunction

  function automatic logic hit(input rec_t r, input logic live,
                               input logic [REG_AW-1:0] a);
    return live && is_producer(r) && (r.rd == a);
  endfunction

  // EX ALU result beats MEM ALU result beats MEM load data.
  function automatic logic [1:0] fwd_sel(input rec_t ex, input rec_t mem,
                                         input logic live,
                                         input logic [REG_AW-1:0] a);
    logic [1:0] sel;
    sel = 2'b00;
    if (hit(ex, live, a) && (ex.optype == OP_ALU))
      sel = 2'b01;
    else if (hit(mem, live, a) && (mem.optype == OP_ALU))
      sel = 2'b10;
    else if (hit(mem, live, a) && (mem.optype == OP_LOAD))
      sel = 2'b11;
    return sel;
  endfunction

  assign live_a = hz_if.id_valid && hz_if.rs1use && (hz_if.rs1_addr != '0);
  assign live_b = hz_if.id_valid && hz_if.rs2use && (hz_if.rs2_addr != '0);

  always_comb begin
    sel_a = fwd_sel(ex_q, mem_q, live_a, hz_if.rs1_addr);
    sel_b = fwd_sel(ex_q, mem_q, live_b, hz_if.rs2_addr);
    lu_a  = hit(ex_q, live_a, hz_if.rs1_addr) && (ex_q.optype == OP_LOAD);
    lu_b  = hit(ex_q, live_b, hz_if.rs2_addr) && (ex_q.optype == OP_LOAD);
    any_a = hit(ex_q, live_a, hz_if.rs1_addr) || hit(mem_q, live_a, hz_if.rs1_addr) ||
            hit(wb_q, live_a, hz_if.rs1_addr);
    any_b = hit(ex_q, live_b, hz_if.rs2_addr) || hit(mem_q, live_b, hz_if.rs2_addr) ||
            hit(wb_q, live_b, hz_if.rs2_addr);
  end

  // Without forwarding every RAW waits until the producer has left WB.
  assign raw_stall = FWD_EN ? (lu_a || lu_b) : (any_a || any_b);
  assign busy      = (st_q == S_BUSY);
  assign stall     = raw_stall || busy;

  assign md_in_id = hz_if.id_valid && ((hz_if.md_op == MD_MUL) || (hz_if.md_op == MD_DIV));
  assign md_go    = md_in_id && !stall;
  assign md_cnt   = (hz_if.md_op == MD_DIV) ? DIV_CNT : MUL_CNT;

  always_comb begin
    id_rec        = BUBBLE;
    id_rec.optype = hz_if.id_valid ? hz_if.hazard_optype : OP_NONE;
    id_rec.rd     = hz_if.rd_addr;
    id_rec.is_md  = md_in_id;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1)
          st_d = S_DONE;
      end
      default: begin
        // DONE can chain straight into the next waiting mul/div.
        st_d = S_IDLE;
        if (md_go) begin
          cnt_d = md_cnt;
          st_d  = (md_cnt == 4'd0) ? S_DONE : S_BUSY;
        end
      end
    endcase
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = stall ? BUBBLE : id_rec;
    if (busy) begin
      ex_d  = ex_q;
      mem_d = BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      st_q  <= S_IDLE;
      cnt_q <= 4'd0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign unused_wb_md = wb_q.is_md;

  assign hz_if.fwd_a      = FWD_EN ? sel_a : 2'b00;
  assign hz_if.fwd_b      = FWD_EN ? sel_b : 2'b00;
  assign hz_if.stall_pc   = stall;
  assign hz_if.stall_ifid = stall;
  assign hz_if.flush_idex = stall;
  assign hz_if.flush_ifid = hz_if.branch_taken && !stall;
  assign hz_if.md_busy    = busy;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: one forwarding and one non-forwarding instance share stimulus
// and are compared each cycle against a stage-array pipeline model.
module tb_hazard_ctrl_unit;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) if0 ();
  hazard_ctrl_if #(.REG_AW(5)) if1 ();

  hazard_ctrl_unit #(.REG_AW(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FWD_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .hz_if(if0)
  );
  hazard_ctrl_unit #(.REG_AW(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FWD_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .hz_if(if1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // current ID stimulus
  logic       s_v, s_u1, s_u2, s_br;
  logic [4:0] s_r1, s_r2, s_rd;
  logic [1:0] s_op, s_md;

  // model: per instance, records for EX/MEM/WB and remaining EX occupancy of a mul/div
  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd;
  } mrec_t;
  mrec_t pipe [2][3];
  int    md_left [2];

  logic obs_stl [2];
  logic obs_busy [2];
  logic obs_flif [2];
  logic [1:0] obs_fa [2];
  logic [1:0] obs_fb [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    if0.id_valid = s_v;  if1.id_valid = s_v;
    if0.rs1_addr = s_r1; if1.rs1_addr = s_r1;
    if0.rs2_addr = s_r2; if1.rs2_addr = s_r2;
    if0.rs1use   = s_u1; if1.rs1use   = s_u1;
    if0.rs2use   = s_u2; if1.rs2use   = s_u2;
    if0.rd_addr  = s_rd; if1.rd_addr  = s_rd;
    if0.hazard_optype = s_op; if1.hazard_optype = s_op;
    if0.md_op    = s_md; if1.md_op    = s_md;
    if0.branch_taken = s_br; if1.branch_taken = s_br;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) pipe[d][s] = '0;
      md_left[d] = 0;
    end
  endtask

  function automatic logic prod_hit(input int d, input int s, input logic [4:0] a);
    return ((pipe[d][s].op == 2'd1) || (pipe[d][s].op == 2'd2)) && (pipe[d][s].rd == a);
  endfunction

  function automatic logic [1:0] model_fwd(input int d, input logic live, input logic [4:0] a);
    if (d == 0 || !live) return 2'd0;
    if (prod_hit(d, 0, a) && pipe[d][0].op == 2'd1) return 2'd1;
    if (prod_hit(d, 1, a) && pipe[d][1].op == 2'd1) return 2'd2;
    if (prod_hit(d, 1, a) && pipe[d][1].op == 2'd2) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic model_raw(input int d, input logic live, input logic [4:0] a);
    if (!live) return 1'b0;
    if (d == 0) return prod_hit(d, 0, a) || prod_hit(d, 1, a) || prod_hit(d, 2, a);
    return prod_hit(d, 0, a) && (pipe[d][0].op == 2'd2);
  endfunction

  task automatic model_adv(input int d, input logic stl);
    if (md_left[d] > 1) begin
      pipe[d][2] = pipe[d][1];
      pipe[d][1] = '0;
      md_left[d]--;
    end else begin
      pipe[d][2] = pipe[d][1];
      pipe[d][1] = pipe[d][0];
      if (stl) begin
        pipe[d][0] = '0;
        md_left[d] = 0;
      end else begin
        pipe[d][0] = {(s_v ? s_op : 2'd0), s_rd};
        if (s_v && s_md == 2'd2)      md_left[d] = DIV_LAT;
        else if (s_v && s_md == 2'd1) md_left[d] = MUL_LAT;
        else                          md_left[d] = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                      input logic [1:0] op, input logic [1:0] md, input logic br);
    logic la, lb;
    logic stl [2];
    logic [3:0] efwd, ofwd;
    logic [4:0] ectl, octl;
    @(negedge clk);
    s_v = v; s_r1 = r1; s_u1 = u1; s_r2 = r2; s_u2 = u2;
    s_rd = rd; s_op = op; s_md = md; s_br = br;
    drive();
    #1;
    la = v && u1 && (r1 != 5'd0);
    lb = v && u2 && (r2 != 5'd0);
    for (int d = 0; d < 2; d++) begin
      stl[d] = model_raw(d, la, r1) || model_raw(d, lb, r2) || (md_left[d] > 1);
      efwd = {model_fwd(d, la, r1), model_fwd(d, lb, r2)};
      ectl = {stl[d], stl[d], stl[d], br && !stl[d], md_left[d] > 1};
      if (d == 0) begin
        ofwd = {if0.fwd_a, if0.fwd_b};
        octl = {if0.stall_pc, if0.stall_ifid, if0.flush_idex, if0.flush_ifid, if0.md_busy};
      end else begin
        ofwd = {if1.fwd_a, if1.fwd_b};
        octl = {if1.stall_pc, if1.stall_ifid, if1.flush_idex, if1.flush_ifid, if1.md_busy};
      end
      chk(d == 0 ? "u0_fwd" : "u1_fwd", {4'd0, ofwd}, {4'd0, efwd});
      chk(d == 0 ? "u0_ctl" : "u1_ctl", {3'd0, octl}, {3'd0, ectl});
      obs_stl[d]  = octl[4];
      obs_flif[d] = octl[1];
      obs_busy[d] = octl[0];
      obs_fa[d]   = ofwd[3:2];
      obs_fb[d]   = ofwd[1:0];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_adv(d, stl[d]);
  endtask

  task automatic nops(input int n);
    repeat (n) step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0);
  endtask

  // Re-present one instruction until instance d stops stalling it.
  task automatic issue(input int d, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic [1:0] op, input logic [1:0] md, input logic br,
                       output int nst, output int nbusy);
    int tries;
    tries = 0; nst = 0; nbusy = 0;
    do begin
      step(1'b1, r1, u1, r2, u2, rd, op, md, br);
      nst   += int'(obs_stl[d]);
      nbusy += int'(obs_busy[d]);
      tries++;
    end while (obs_stl[d] && tries < 40);
    chk("issue_bound", {7'd0, obs_stl[d]}, 8'd0);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {1'b0, if0.fwd_a, if0.fwd_b, if0.stall_pc, if0.stall_ifid, if0.flush_ifid,
              if0.flush_idex, if0.md_busy}, 8'd0);
    chk(tag, {1'b0, if1.fwd_a, if1.fwd_b, if1.stall_pc, if1.stall_ifid, if1.flush_ifid,
              if1.flush_idex, if1.md_busy}, 8'd0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    s_v = 1'b0; s_u1 = 1'b0; s_u2 = 1'b0; s_br = 1'b0; s_md = 2'd0; s_op = 2'd0;
    drive();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst, nb, acc;
    logic       rv, ru1, ru2, rbr;
    logic [4:0] rr1, rr2, rrd;
    logic [1:0] rop, rmd;

    rst = 1'b1;
    s_v = 1'b0; s_r1 = '0; s_r2 = '0; s_u1 = 1'b0; s_u2 = 1'b0;
    s_rd = '0; s_op = '0; s_md = '0; s_br = 1'b0;
    drive();
    model_reset();
    #3;
    check_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // add x5 ; sub using x5 -> EX forward
    nops(4);
    issue(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 2'd1, 2'd0, 1'b0, nst, nb);
    issue(1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("ex_fwd_a", {6'd0, obs_fa[1]}, 8'd1);
    chk("ex_fwd_nostall", 8'(nst), 8'd0);

    // add x5 ; independent ; use x5 -> MEM ALU forward
    nops(4);
    issue(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 2'd1, 2'd0, 1'b0, nst, nb);
    issue(1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 2'd1, 2'd0, 1'b0, nst, nb);
    issue(1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("mem_fwd_a", {6'd0, obs_fa[1]}, 8'd2);
    chk("mem_fwd_nostall", 8'(nst), 8'd0);

    // lw x6 ; add using x6 -> one stall then load-data forward
    nops(4);
    issue(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 2'd2, 2'd0, 1'b0, nst, nb);
    issue(1, 5'd3, 1'b1, 5'd6, 1'b1, 5'd7, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("loaduse_stalls", 8'(nst), 8'd1);
    chk("loaduse_fwd_b", {6'd0, obs_fb[1]}, 8'd3);

    // div x10 ; add using x10 -> 7 busy cycles then EX forward on DONE
    nops(4);
    issue(1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 2'd1, 2'd2, 1'b0, nst, nb);
    issue(1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd12, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("div_stalls", 8'(nst), 8'd7);
    chk("div_busy_cycles", 8'(nb), 8'd7);
    chk("div_done_fwd_a", {6'd0, obs_fa[1]}, 8'd1);

    // taken branch while load-use stalled: suppressed, then honoured
    nops(4);
    issue(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 2'd2, 2'd0, 1'b0, nst, nb);
    step(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1);
    chk("br_in_stall_flush", {7'd0, obs_flif[1]}, 8'd0);
    chk("br_in_stall_stall", {7'd0, obs_stl[1]}, 8'd1);
    step(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1);
    chk("br_after_flush", {7'd0, obs_flif[1]}, 8'd1);

    // no-forward instance: add x7 ; use x7 -> 3 stalls; x0 writes never stall
    nops(4);
    issue(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 2'd1, 2'd0, 1'b0, nst, nb);
    issue(0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("nofwd_stalls", 8'(nst), 8'd3);
    chk("nofwd_fwd_a", {6'd0, obs_fa[0]}, 8'd0);
    nops(4);
    issue(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1, 2'd0, 1'b0, nst, nb);
    issue(0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("x0_nostall", 8'(nst), 8'd0);

    // reset in the middle of a divide
    nops(4);
    issue(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 2'd1, 2'd2, 1'b0, nst, nb);
    nops(3);
    chk("div_busy_before_rst", {7'd0, obs_busy[1]}, 8'd1);
    pulse_rst();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      nops(1);
      acc += int'(obs_busy[1]) + int'(obs_stl[1]);
    end
    chk("post_rst_quiet", 8'(acc), 8'd0);
    issue(1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 2'd1, 2'd0, 1'b0, nst, nb);
    chk("post_rst_fwd_a", {6'd0, obs_fa[1]}, 8'd0);

    // random traffic against the model
    for (int i = 0; i < 900; i++) begin
      rv  = ($urandom_range(0, 7) != 0);
      rr1 = 5'($urandom_range(0, 7));
      rr2 = 5'($urandom_range(0, 7));
      ru1 = 1'($urandom_range(0, 1));
      ru2 = 1'($urandom_range(0, 1));
      rrd = 5'($urandom_range(0, 7));
      rop = 2'($urandom_range(0, 3));
      rmd = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rbr = ($urandom_range(0, 5) == 0);
      step(rv, rr1, ru1, rr2, ru2, rrd, rop, rmd, rbr);
      if (i % 300 == 299) pulse_rst();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
